alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU instance between two requesters, e.g. EXU and
//  an address/branch helper. Uses a valid/ready request channel per requester
//  and one shared, tagged response channel.
//  Round-robin grant; one operation in flight; result registered before return.
//  Sits between the requesting units and the ALU (A/B/ALUSel/CompUn in;
//  Results/BrEq/BrLT out).
// PARAMETERS
//  WIDTH  32  operand/result width; must match the ALU instance
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  req_valid    in   2        bit i: requester i presents an op
//  req_ready    out  2        bit i: op from requester i accepted this cycle
//  req_a        in   2*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
//  req_b        in   2*WIDTH  operand B, same packing
//  req_alusel   in   8        ALUSel; requester i at [i*4 +: 4]
//  req_compun   in   2        CompUn per requester
//  alu_a        out  WIDTH    to ALU A
//  alu_b        out  WIDTH    to ALU B
//  alu_sel      out  4        to ALU ALUSel
//  alu_compun   out  1        to ALU CompUn
//  alu_result   in   WIDTH    from ALU Results
//  alu_breq     in   1        from ALU BrEq
//  alu_brlt     in   1        from ALU BrLT
//  rsp_valid    out  1        response valid
//  rsp_ready    in   1        consumer accepts response
//  rsp_id       out  1        requester index the response belongs to
//  rsp_result   out  WIDTH    registered ALU result
//  rsp_breq     out  1        registered BrEq
//  rsp_brlt     out  1        registered BrLT
//  busy         out  1        1 whenever state != IDLE
// BEHAVIOUR
//  FSM states: IDLE -> ISSUE -> RESP -> IDLE. Reset state: IDLE.
//  IDLE:
//   - Grant g: if exactly one req_valid bit is set, that bit.
//     If both are set, g = ~last_grant.
//   - req_ready[g] = 1 combinationally; the other bit is 0.
//     Both bits are 0 when req_valid == 0.
//   - On grant: latch req_a/b/alusel/compun[g] into operand regs.
//     Set last_grant <= g and id <= g, then go to ISSUE.
//  ISSUE:
//   - alu_* are driven from the operand regs; the ALU is combinational.
//   - Capture alu_result/breq/brlt into response regs, then go to RESP.
//  RESP:
//   - rsp_valid = 1, with data and rsp_id held stable until rsp_ready.
//   - On rsp_valid & rsp_ready: go to IDLE.
//   - No new grant in that cycle; the earliest next accept is one cycle later.
//  alu_a/b/sel/compun always equal the operand regs; they never pass req_* through.
//  req_ready is 0 in ISSUE and RESP regardless of req_valid.
//  Timing:
//   - Latency: accept at cycle N, rsp_valid asserted from cycle N+2.
//   - Peak throughput: one op per 3 cycles.
//  Requester rule: payload held stable while req_valid & ~req_ready.
//  req_valid must not depend on req_ready.
//  Round-robin tie-break: each requester wins at most every other contended
//  grant. An uncontended grant still updates last_grant.
//  Reset values:
//   - state=IDLE; last_grant=1, so requester 0 wins the first tie.
//   - Operand regs 0, alu_sel=4'h0, alu_compun=0.
//   - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_breq=0, rsp_brlt=0, busy=0, req_ready=0.
//  Reset mid-operation: the in-flight op is dropped with no response.
//  Everything returns to the reset values above.
//  A requester dropping req_valid while waiting is not an error; it simply is
//  not granted.
//  Widths: packed buses are indexed by requester. No arithmetic is done here;
//  result bits pass through unchanged.
// TESTING
//  1. Single op: req0 A=5, B=3, ALUSel=ADD.
//     -> ready0 in cycle 0; rsp_valid in cycle 2 with result=8, rsp_id=0.
//  2. Contention: both valid from reset.
//     -> grants in order 0,1,0,1; rsp_id follows the same order.
//  3. Backpressure: hold rsp_ready=0 for 5 cycles.
//     -> rsp_* stable; req_ready=2'b00; accept occurs only after the handshake plus 1 cycle.
//  4. Compare flags: req1 A=32'hFFFFFFFF, B=1, SUB.
//     -> CompUn=1 gives brlt=0; CompUn=0 gives brlt=1; breq=0 in both.
//  5. Async reset asserted in ISSUE.
//     -> all outputs at reset values immediately; no response after release.
//     -> next tie is granted to requester 0.
//  6. Payload change while unselected: req1 waits while req0 is served, and
//     req1 changes nothing.
//     -> req1's op is issued with its original operands; result matches the ALU model.

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grant,
// a single operation in flight, and a registered, tagged response.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [7:0]         req_alusel,
  input  logic [1:0]         req_compun,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_sel,
  output logic               alu_compun,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_breq,
  input  logic               alu_brlt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_breq,
  output logic               rsp_brlt,
  output logic               busy
);

  // Handshake: a request transfers on an edge where req_valid[i] & req_ready[i];
  // the response transfers on an edge where rsp_valid & rsp_ready.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [3:0]       op_sel_q, op_sel_d;
  logic             op_cu_q, op_cu_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             breq_q, breq_d;
  logic             brlt_q, brlt_d;
  logic             grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    op_cu_d      = op_cu_q;
    res_d        = res_q;
    breq_d       = breq_q;
    brlt_d       = brlt_q;
    grant        = 1'b0;
    req_ready    = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          // Ties alternate; a lone requester wins and still moves last_grant.
          grant           = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
          req_ready[grant] = 1'b1;
          op_a_d          = grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          op_b_d          = grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          op_sel_d        = grant ? req_alusel[7:4] : req_alusel[3:0];
          op_cu_d         = req_compun[grant];
          last_grant_d    = grant;
          id_d            = grant;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        res_d   = alu_result;
        breq_d  = alu_breq;
        brlt_d  = alu_brlt;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= 4'h0;
      op_cu_q      <= 1'b0;
      res_q        <= '0;
      breq_q       <= 1'b0;
      brlt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      op_cu_q      <= op_cu_d;
      res_q        <= res_d;
      breq_q       <= breq_d;
      brlt_q       <= brlt_d;
    end
  end

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_sel    = op_sel_q;
  assign alu_compun = op_cu_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_breq   = breq_q;
  assign rsp_brlt   = brlt_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level
// model: one op in flight, response two cycles after accept, round-robin ties.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR = 4'd3, OP_XOR = 4'd4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [1:0]     req_valid = '0;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a = '0, req_b = '0;
  logic [7:0]     req_alusel = '0;
  logic [1:0]     req_compun = '0;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [3:0]     alu_sel;
  logic           alu_compun, alu_breq, alu_brlt;
  logic           rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_breq, rsp_brlt, busy;
  logic [W-1:0]   rsp_result;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_alusel(req_alusel), .req_compun(req_compun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_compun(alu_compun),
    .alu_result(alu_result), .alu_breq(alu_breq), .alu_brlt(alu_brlt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_breq(rsp_breq), .rsp_brlt(rsp_brlt), .busy(busy)
  );

  // ---------------- clock / ALU ----------------
  always #5 clk = ~clk;

  // returns {breq, brlt, result}
  function automatic logic [W+1:0] alu_f(input logic [W-1:0] a, b,
                                         input logic [3:0] sel, input logic cu);
    logic [W-1:0] r;
    logic lt;
    case (sel)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a;
    endcase
    lt = cu ? (a < b) : ($signed(a) < $signed(b));
    return {(a == b), lt, r};
  endfunction

  logic [W+1:0] alu_out;
  always_comb begin
    alu_out    = alu_f(alu_a, alu_b, alu_sel, alu_compun);
    alu_result = alu_out[W-1:0];
    alu_brlt   = alu_out[W];
    alu_breq   = alu_out[W+1];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W+1:0] exp_q[$];
  logic         id_q[$];
  int           grant_log[$];
  int           cyc = 0;
  bit           m_busy = 0;
  bit           m_last = 1;
  int           m_acc_cyc = 0;
  logic [W-1:0] m_a, m_b;
  logic [3:0]   m_sel;
  logic         m_cu;
  int           hs_cyc = -1, acc_cyc = -1;
  logic [1:0]   obs_ready;
  logic         obs_rv, obs_id, obs_breq, obs_brlt;
  logic [W-1:0] obs_result;

  task automatic model_reset();
    m_busy = 0;
    m_last = 1;
    exp_q.delete();
    id_q.delete();
    grant_log.delete();
    hs_cyc = -1;
    acc_cyc = -1;
  endtask

  // One clock: check at negedge, advance the model, return #1 after posedge.
  task automatic cycle();
    logic [1:0] exp_ready;
    bit         exp_rv;
    int         g;
    @(negedge clk);
    exp_ready = 2'b00;
    g = 0;
    if (!m_busy && req_valid != 2'b00) begin
      if (req_valid == 2'b11) g = m_last ? 0 : 1;
      else g = req_valid[1] ? 1 : 0;
      exp_ready[g] = 1'b1;
    end
    exp_rv = m_busy && (cyc - m_acc_cyc >= 2);
    obs_ready  = req_ready;
    obs_rv     = rsp_valid;
    obs_id     = rsp_id;
    obs_result = rsp_result;
    obs_breq   = rsp_breq;
    obs_brlt   = rsp_brlt;
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, m_busy);
    check("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      check("rsp_id", rsp_id, id_q[0]);
      check("rsp_data", {rsp_breq, rsp_brlt, rsp_result}, exp_q[0]);
    end
    if (m_busy) check("alu_operands", {alu_a, alu_b, alu_sel, alu_compun},
                      {m_a, m_b, m_sel, m_cu});
    if (exp_ready != 2'b00) begin
      m_busy    = 1;
      m_acc_cyc = cyc;
      m_last    = g[0];
      m_a       = req_a[g*W +: W];
      m_b       = req_b[g*W +: W];
      m_sel     = req_alusel[g*4 +: 4];
      m_cu      = req_compun[g];
      exp_q.push_back(alu_f(m_a, m_b, m_sel, m_cu));
      id_q.push_back(g[0]);
      grant_log.push_back(g);
      acc_cyc = cyc;
    end else if (exp_rv && rsp_ready) begin
      m_busy = 0;
      void'(exp_q.pop_front());
      void'(id_q.pop_front());
      hs_cyc = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input int i, input logic [W-1:0] a, b,
                         input logic [3:0] sel, input logic cu);
    req_a[i*W +: W]     = a;
    req_b[i*W +: W]     = b;
    req_alusel[i*4 +: 4] = sel;
    req_compun[i]       = cu;
    req_valid[i]        = 1'b1;
  endtask

  task automatic set_rand_req(input int i);
    logic [W-1:0] a, b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    set_req(i, a, b, 4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rsp"}, {rsp_valid, rsp_id, rsp_breq, rsp_brlt, rsp_result}, '0);
    check({tag, "_alu"}, {alu_a, alu_b, alu_sel, alu_compun}, '0);
    check({tag, "_ready"}, req_ready, 2'b00);
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [W-1:0] held;
    bit seen;

    do_reset();
    check_reset_outputs("reset");

    // single op on requester 0
    set_req(0, 5, 3, OP_ADD, 1'b0);
    cycle();
    check("t1_ready0", obs_ready, 2'b01);
    req_valid = 2'b00;
    cycle();
    check("t1_no_rsp_yet", obs_rv, 1'b0);
    cycle();
    check("t1_rsp", {obs_rv, obs_id, obs_result}, {1'b1, 1'b0, 32'd8});

    // contention from reset: grants alternate starting with 0
    do_reset();
    set_req(0, 100, 1, OP_SUB, 1'b0);
    set_req(1, 6, 12, OP_OR, 1'b1);
    for (int k = 0; k < 40 && grant_log.size() < 4; k++) cycle();
    check("t2_grants", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check($sformatf("t2_grant%0d", k), grant_log[k], k % 2);

    // backpressure: response held for 5 cycles, next accept one after handshake
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 10, 20, OP_ADD, 1'b0);
    set_req(1, 3, 4, OP_AND, 1'b0);
    cycle();
    req_valid[0] = 1'b0;
    cycle();
    cycle();
    held = obs_result;
    check("t3_first", {obs_rv, held}, {1'b1, 32'd30});
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t3_stable", {obs_rv, obs_id, obs_result, obs_ready}, {1'b1, 1'b0, held, 2'b00});
    end
    rsp_ready = 1'b1;
    cycle();
    check("t3_hs_no_accept", obs_ready, 2'b00);
    cycle();
    check("t3_accept_next", {obs_ready, 32'(acc_cyc - hs_cyc)}, {2'b10, 32'd1});
    req_valid = 2'b00;
    repeat (3) cycle();

    // compare flags, unsigned then signed
    do_reset();
    set_req(1, 32'hFFFF_FFFF, 32'd1, OP_SUB, 1'b1);
    cycle();
    req_compun[1] = 1'b0;
    cycle();
    cycle();
    check("t4_unsigned", {obs_rv, obs_id, obs_breq, obs_brlt, obs_result},
          {1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE});
    cycle();
    req_valid = 2'b00;
    cycle();
    cycle();
    check("t4_signed", {obs_rv, obs_breq, obs_brlt}, {1'b1, 1'b0, 1'b1});

    // async reset while in ISSUE
    do_reset();
    set_req(0, 1, 2, OP_ADD, 1'b0);
    cycle();
    rst = 1'b1;
    req_valid = 2'b00;
    #1;
    check_reset_outputs("t5_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (obs_rv) seen = 1;
    end
    check("t5_no_rsp", seen, 1'b0);
    set_req(0, 9, 9, OP_XOR, 1'b0);
    set_req(1, 8, 8, OP_XOR, 1'b0);
    cycle();
    check("t5_tie_to_0", obs_ready, 2'b01);
    req_valid = 2'b00;
    repeat (3) cycle();

    // requester 1 waits unchanged while requester 0 is served
    do_reset();
    set_req(0, 40, 2, OP_SUB, 1'b0);
    set_req(1, 7, 9, OP_XOR, 1'b0);
    cycle();
    req_valid[0] = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle();
      if (obs_ready[1]) req_valid[1] = 1'b0;
      if (obs_rv && obs_id) begin
        seen = 1;
        check("t6_result", obs_result, 32'd14);
      end
    end
    check("t6_seen", seen, 1'b1);
    repeat (2) cycle();

    // randomized traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && obs_ready[i]) begin
          if ($urandom_range(0, 1) == 0) set_rand_req(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) set_rand_req(i);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      obs_ready = 2'b00;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
